// File: rtl/ripple_carry_adder.sv
// Registered WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
// Results, carry-out and status flags appear one clock after a valid input.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             Zero,
    output logic             out_valid
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;
    logic             ovf_c;

    assign carry[0] = Cin;

    // Carry ripples cell to cell; no lookahead by design.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry[i]),
            .s  (sum_c[i]),
            .co (carry[i+1])
        );
    end

    assign ovf_c = carry[WIDTH] ^ carry[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            Sum       <= '0;
            Cout      <= 1'b0;
            Overflow  <= 1'b0;
            Zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sum      <= sum_c;
                Cout     <= carry[WIDTH];
                Overflow <= ovf_c;
                // Same value as ~|Sum after this edge, kept as a flop.
                Zero     <= ~|sum_c;
            end
        end
    end
endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder: directed vector table, hold/reset
// sequences and randomized back-to-back traffic against an arithmetic model.

module tb_ripple_carry_adder;
    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] A, B;
    logic             Cin;
    logic [WIDTH-1:0] Sum;
    logic             Cout, Overflow, Zero, out_valid;

    int checks = 0;
    int errors = 0;

    ripple_carry_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sum       (Sum),
        .Cout      (Cout),
        .Overflow  (Overflow),
        .Zero      (Zero),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned and signed integer arithmetic.
    function automatic vec_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin);
        vec_t r;
        int   u, s;
        u = int'(a) + int'(b) + int'(cin);
        s = int'($signed(a)) + int'($signed(b)) + int'(cin);
        r.a    = a;
        r.b    = b;
        r.cin  = cin;
        r.sum  = WIDTH'(u % (1 << WIDTH));
        r.cout = (u >= (1 << WIDTH));
        r.ovf  = (s > (1 << (WIDTH-1)) - 1) || (s < -(1 << (WIDTH-1)));
        r.zero = (u % (1 << WIDTH)) == 0;
        return r;
    endfunction

    task automatic check(input string name, input vec_t e, input logic ov);
        checks++;
        if (Sum !== e.sum || Cout !== e.cout || Overflow !== e.ovf ||
            Zero !== e.zero || out_valid !== ov) begin
            errors++;
            $display("FAIL %s: got sum=%h cout=%b ovf=%b zero=%b ov=%b, want sum=%h cout=%b ovf=%b zero=%b ov=%b",
                     name, Sum, Cout, Overflow, Zero, out_valid,
                     e.sum, e.cout, e.ovf, e.zero, ov);
        end
    endtask

    vec_t tbl[6];
    vec_t rst_exp, last, e;

    initial begin
        tbl[0] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{4'hF, 4'hF, 1'b0, 4'hE, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{4'h3, 4'h5, 1'b1, 4'h9, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{4'h8, 4'h8, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{4'h7, 4'h0, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1};
        rst_exp = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", rst_exp, 1'b0);

        // Directed table, back-to-back valids.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            A = tbl[i].a; B = tbl[i].b; Cin = tbl[i].cin; in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("table_%0d", i), tbl[i], 1'b1);
        end
        last = tbl[5];

        // Idle with changing operands: outputs must hold.
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            A = 4'h5 + 4'(i); B = 4'h6; Cin = 1'b1;
            @(negedge clk);
            check($sformatf("hold_%0d", i), last, 1'b0);
        end

        // Reset on the same edge as a valid input drops that input.
        A = 4'h5; B = 4'h6; Cin = 1'b0; in_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        check("reset_with_valid", rst_exp, 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("after_reset_idle", rst_exp, 1'b0);

        // Randomized back-to-back traffic.
        for (int i = 0; i < 16; i++) begin
            A = WIDTH'($urandom); B = WIDTH'($urandom); Cin = 1'($urandom);
            in_valid = 1'b1;
            e = model(A, B, Cin);
            @(negedge clk);
            check($sformatf("rand_%0d", i), e, 1'b1);
        end
        last = e;

        in_valid = 1'b0;
        @(negedge clk);
        check("final_hold", last, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
